// File: rtl/logisim_clock_sequencer.sv
// -----------------------------------------------------------------------------
// logisim_clock_sequencer
//
// Purpose
//   Run-control for the Logisim clock tree. It divides i_fpgaGlobalClock into
//   ticks with a reloadable prescaler. It then shapes those ticks into a
//   derived circuit clock that has a low phase and a high phase. The HALT,
//   RUN, STEP and LOAD commands start and stop that clock. The sequencer only
//   ever stops at the start of a low phase, so the circuit always sees whole
//   clock periods.
//
// Ports
//   i_fpgaGlobalClock   in   1           sole clock, rising edge
//   i_fpgaGlobalResetN  in   1           asynchronous active-low reset
//   i_cmdValid          in   1           command strobe
//   o_cmdReady          out  1           command taken when valid && ready at an edge
//   i_cmdOp             in   2           00 HALT, 01 RUN, 10 STEP, 11 LOAD
//   i_cmdArg            in   NR_OF_BITS  STEP count (low STEP_BITS bits) or reload value
//   o_clockBus          out  5           [0] clk, [1] posedge pulse, [2] negedge pulse,
//                                        [3] ~clk, [4] tick
//   o_running           out  1           1 while the sequencer is not halted
//   o_cycleCount        out  32          completed clk periods (falling edges)
//
// Build option
//   CLKSEQ_CYCLE_COUNTER_EN : when this macro is defined, o_cycleCount counts
//   falling edges and wraps around. When it is not defined, o_cycleCount is
//   tied to zero and no counter is built.
// -----------------------------------------------------------------------------
module logisim_clock_sequencer #(
    parameter int          NR_OF_BITS     = 31,
    parameter int unsigned DEFAULT_RELOAD = 2147483647,
    parameter int          HIGH_TICKS     = 1,
    parameter int          LOW_TICKS      = 1,
    parameter int          STEP_BITS      = 16
) (
    input  logic                  i_fpgaGlobalClock,
    input  logic                  i_fpgaGlobalResetN,
    input  logic                  i_cmdValid,
    output logic                  o_cmdReady,
    input  logic [1:0]            i_cmdOp,
    input  logic [NR_OF_BITS-1:0] i_cmdArg,
    output logic [4:0]            o_clockBus,
    output logic                  o_running,
    output logic [31:0]           o_cycleCount
);

    typedef enum logic [1:0] {
        ST_HALT     = 2'd0,
        ST_RUN      = 2'd1,
        ST_STEP     = 2'd2,
        ST_STOPPING = 2'd3
    } state_t;

    localparam logic [1:0] OP_HALT = 2'b00;
    localparam logic [1:0] OP_RUN  = 2'b01;
    localparam logic [1:0] OP_STEP = 2'b10;
    localparam logic [1:0] OP_LOAD = 2'b11;

    // The phase counter only has to hold 0 .. max(HIGH_TICKS, LOW_TICKS)-1.
    localparam int MAX_TICKS = (HIGH_TICKS > LOW_TICKS) ? HIGH_TICKS : LOW_TICKS;
    localparam int PH_W      = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;

    localparam logic [PH_W-1:0]       LOW_LAST   = PH_W'(LOW_TICKS - 1);
    localparam logic [PH_W-1:0]       HIGH_LAST  = PH_W'(HIGH_TICKS - 1);
    localparam logic [PH_W-1:0]       PH_ONE     = PH_W'(1);
    localparam logic [NR_OF_BITS-1:0] PS_ONE     = NR_OF_BITS'(1);
    localparam logic [NR_OF_BITS-1:0] RELOAD_RST = NR_OF_BITS'(DEFAULT_RELOAD);
    localparam logic [STEP_BITS-1:0]  STEP_ONE   = STEP_BITS'(1);

    state_t                r_state;
    logic [NR_OF_BITS-1:0] r_prescaler;
    logic [NR_OF_BITS-1:0] r_reload;
    logic                  r_clk;
    logic [PH_W-1:0]       r_phase_cnt;
    logic [STEP_BITS-1:0]  r_step_rem;
    logic [4:0]            r_clock_bus;
    logic                  r_running;

    state_t                w_state_next;
    logic [NR_OF_BITS-1:0] w_prescaler_next;
    logic [NR_OF_BITS-1:0] w_reload_next;
    logic                  w_clk_next;
    logic [PH_W-1:0]       w_phase_cnt_next;
    logic [STEP_BITS-1:0]  w_step_rem_next;
    logic [4:0]            w_clock_bus_next;

    logic                  w_accept;
    logic                  w_tick;
    logic                  w_phase_last;
    logic                  w_pos;
    logic                  w_neg;
    logic [STEP_BITS-1:0]  w_step_n;

    // The STEP count is the low STEP_BITS bits of the argument. If the
    // argument is narrower than that, the count is zero-extended.
    generate
        if (STEP_BITS <= NR_OF_BITS) begin : gen_step_slice
            assign w_step_n = i_cmdArg[STEP_BITS-1:0];
        end else begin : gen_step_zext
            assign w_step_n = {{(STEP_BITS-NR_OF_BITS){1'b0}}, i_cmdArg};
        end
    endgenerate

    assign o_cmdReady = (r_state == ST_HALT) || (r_state == ST_RUN);
    assign w_accept   = i_cmdValid && o_cmdReady;

    // A tick fires on the edge at which the prescaler sits at zero. The new
    // clock level and the edge pulse are registered on that same edge.
    assign w_tick       = (r_state != ST_HALT) && (r_prescaler == '0);
    assign w_phase_last = r_clk ? (r_phase_cnt == HIGH_LAST) : (r_phase_cnt == LOW_LAST);
    assign w_pos        = w_tick && !r_clk && w_phase_last;
    assign w_neg        = w_tick &&  r_clk && w_phase_last;

    always_comb begin
        w_state_next     = r_state;
        w_reload_next    = r_reload;
        w_step_rem_next  = r_step_rem;
        w_clk_next       = r_clk;
        w_phase_cnt_next = r_phase_cnt;
        w_prescaler_next = r_prescaler;

        if (r_state != ST_HALT) begin
            w_prescaler_next = w_tick ? r_reload : (r_prescaler - PS_ONE);
        end

        if (w_tick) begin
            w_phase_cnt_next = w_phase_last ? '0 : (r_phase_cnt + PH_ONE);
            if (w_pos) begin
                w_clk_next = 1'b1;
            end else if (w_neg) begin
                w_clk_next = 1'b0;
            end
        end

        case (r_state)
            ST_HALT: begin
                if (w_accept) begin
                    case (i_cmdOp)
                        OP_RUN: begin
                            w_state_next     = ST_RUN;
                            w_prescaler_next = r_reload;
                        end
                        OP_STEP: begin
                            if (w_step_n != '0) begin
                                w_state_next     = ST_STEP;
                                w_step_rem_next  = w_step_n;
                                w_prescaler_next = r_reload;
                            end
                        end
                        OP_LOAD: w_reload_next = i_cmdArg;
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                if (w_accept) begin
                    case (i_cmdOp)
                        // If a falling edge happens on this same edge, we are
                        // already at the start of a low phase and can stop at
                        // once.
                        OP_HALT, OP_STEP: w_state_next = w_neg ? ST_HALT : ST_STOPPING;
                        // The new reload value takes effect at the next reload
                        // and does not cut short the current count.
                        OP_LOAD:          w_reload_next = i_cmdArg;
                        default: ;
                    endcase
                end
            end
            ST_STEP: begin
                if (w_neg) begin
                    if (r_step_rem == STEP_ONE) begin
                        w_state_next    = ST_HALT;
                        w_step_rem_next = '0;
                    end else begin
                        w_step_rem_next = r_step_rem - STEP_ONE;
                    end
                end
            end
            ST_STOPPING: begin
                if (w_neg) begin
                    w_state_next = ST_HALT;
                end
            end
            default: w_state_next = ST_HALT;
        endcase

        w_clock_bus_next = {w_tick, ~w_clk_next, w_neg, w_pos, w_clk_next};
    end

    always_ff @(posedge i_fpgaGlobalClock or negedge i_fpgaGlobalResetN) begin
        if (!i_fpgaGlobalResetN) begin
            r_state     <= ST_HALT;
            r_prescaler <= RELOAD_RST;
            r_reload    <= RELOAD_RST;
            r_clk       <= 1'b0;
            r_phase_cnt <= '0;
            r_step_rem  <= '0;
            r_clock_bus <= 5'b01000;
            r_running   <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_prescaler <= w_prescaler_next;
            r_reload    <= w_reload_next;
            r_clk       <= w_clk_next;
            r_phase_cnt <= w_phase_cnt_next;
            r_step_rem  <= w_step_rem_next;
            r_clock_bus <= w_clock_bus_next;
            // Registered from the next state, so o_running drops in the same
            // cycle in which the final negedge pulse is visible.
            r_running   <= (w_state_next != ST_HALT);
        end
    end

    assign o_clockBus = r_clock_bus;
    assign o_running  = r_running;

`ifdef CLKSEQ_CYCLE_COUNTER_EN
    logic [31:0] r_cycle_count;

    always_ff @(posedge i_fpgaGlobalClock or negedge i_fpgaGlobalResetN) begin
        if (!i_fpgaGlobalResetN) begin
            r_cycle_count <= 32'd0;
        end else if (w_neg) begin
            r_cycle_count <= r_cycle_count + 32'd1;
        end
    end

    assign o_cycleCount = r_cycle_count;
`else
    assign o_cycleCount = 32'd0;
`endif

endmodule
